// File: rtl/mac_seq_ctrl.sv
// Sequencer for a 4-lane signed 8-bit MAC datapath: buffers packed A/B operands,
// steps the datapath one entry per mac_start and hands back the four accumulators.
module mac_seq_ctrl #(
  parameter int DEPTH = 16,
  parameter int AW    = 4
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          wr_en,
  input  logic [AW-1:0] wr_addr,
  input  logic [31:0]   wr_a,
  input  logic [31:0]   wr_b,
  input  logic [AW:0]   len,
  input  logic          go,
  output logic          busy,
  output logic          err,
  output logic          mac_clr,
  output logic          mac_start,
  output logic [31:0]   mac_a,
  output logic [31:0]   mac_b,
  input  logic          mac_done,
  input  logic [127:0]  mac_o,
  output logic          res_valid,
  input  logic          res_ready,
  output logic [127:0]  res_data
);

  typedef enum logic [2:0] {S_IDLE, S_CLEAR, S_ISSUE, S_WAIT, S_OUT} state_t;

  localparam logic [AW:0] DEPTH_L = (AW+1)'(DEPTH);

  state_t        state_q, state_d;
  logic [AW-1:0] idx_q, idx_d;
  logic [AW:0]   k_q, k_d;
  logic [63:0]   mem_q [DEPTH];

  logic          busy_q, busy_d;
  logic          err_q, err_d;
  logic          mac_clr_q, mac_clr_d;
  logic          mac_start_q, mac_start_d;
  logic [31:0]   mac_a_q, mac_a_d;
  logic [31:0]   mac_b_q, mac_b_d;
  logic          res_valid_q, res_valid_d;
  logic [127:0]  res_data_q, res_data_d;

  // Operand buffer: entry = {B, A}; frozen whenever a run is in flight.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
    end else if (wr_en && !busy_q) begin
      mem_q[wr_addr] <= {wr_b, wr_a};
    end
  end

  always_comb begin
    state_d    = state_q;
    idx_d      = idx_q;
    k_d        = k_q;
    res_data_d = res_data_q;
    err_d      = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (go) begin
          if (len != '0 && len <= DEPTH_L) begin
            state_d = S_CLEAR;
            k_d     = len;
            idx_d   = '0;
          end else begin
            err_d = 1'b1;
          end
        end
      end
      S_CLEAR: state_d = S_ISSUE;
      S_ISSUE: state_d = S_WAIT;
      S_WAIT: begin
        if (mac_done) begin
          if ({1'b0, idx_q} == k_q - 1'b1) begin
            res_data_d = mac_o;
            state_d    = S_OUT;
          end else begin
            idx_d   = idx_q + 1'b1;
            state_d = S_ISSUE;
          end
        end
      end
      S_OUT: begin
        if (res_ready) state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase

    // Outputs are decoded from the next state so they line up with the state register.
    busy_d      = (state_d != S_IDLE);
    mac_clr_d   = (state_d == S_CLEAR);
    mac_start_d = (state_d == S_ISSUE);
    res_valid_d = (state_d == S_OUT);
    mac_a_d     = '0;
    mac_b_d     = '0;
    if (state_d == S_ISSUE || state_d == S_WAIT) begin
      mac_a_d = mem_q[idx_d][31:0];
      mac_b_d = mem_q[idx_d][63:32];
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= S_IDLE;
      idx_q       <= '0;
      k_q         <= '0;
      busy_q      <= 1'b0;
      err_q       <= 1'b0;
      mac_clr_q   <= 1'b0;
      mac_start_q <= 1'b0;
      mac_a_q     <= '0;
      mac_b_q     <= '0;
      res_valid_q <= 1'b0;
      res_data_q  <= '0;
    end else begin
      state_q     <= state_d;
      idx_q       <= idx_d;
      k_q         <= k_d;
      busy_q      <= busy_d;
      err_q       <= err_d;
      mac_clr_q   <= mac_clr_d;
      mac_start_q <= mac_start_d;
      mac_a_q     <= mac_a_d;
      mac_b_q     <= mac_b_d;
      res_valid_q <= res_valid_d;
      res_data_q  <= res_data_d;
    end
  end

  assign busy      = busy_q;
  assign err       = err_q;
  assign mac_clr   = mac_clr_q;
  assign mac_start = mac_start_q;
  assign mac_a     = mac_a_q;
  assign mac_b     = mac_b_q;
  assign res_valid = res_valid_q;
  assign res_data  = res_data_q;

endmodule

// File: doc/mac_seq_ctrl.md
# mac_seq_ctrl

Sequencer for the 4-lane signed 8-bit MAC array (`ai_accel`-class datapath). It holds a small operand buffer of packed 4-lane A/B vectors and, on `go`, clears the array accumulators. It then issues one `mac_start` per buffered entry, waiting for `mac_done` between steps, and presents the four 32-bit accumulator results on a valid/ready output port. Software or an upstream loader fills the buffer; a downstream consumer drains results.

## Interface
Parameters:
- `DEPTH`, 16: operand buffer entries (max vector length K); power of two.
- `AW`, 4: log2(DEPTH).

Ports:
- `clk`  in  1  clock, rising edge.
- `rst_n`  in  1  reset, asynchronous assert, active-low.
- `wr_en`  in  1  buffer write strobe; ignored while `busy`.
- `wr_addr`  in  AW  buffer entry to write.
- `wr_a`  in  32  packed A lanes, lane i = bits [8i+7:8i], signed.
- `wr_b`  in  32  packed B lanes, same packing.
- `len`  in  AW+1  step count K; sampled with `go`; legal 1..DEPTH.
- `go`  in  1  start a run; honoured only in IDLE.
- `busy`  out  1  high in every state except IDLE.
- `err`  out  1  one-cycle pulse when `go` is sampled in IDLE with illegal `len`.
- `mac_clr`  out  1  one-cycle synchronous accumulator clear to the datapath.
- `mac_start`  out  1  one-cycle MAC issue pulse.
- `mac_a`, `mac_b`  out  32  packed operands to the datapath (lanes 0..3 → a0..a3 / b0..b3).
- `mac_done`  in  1  one-cycle pulse from the datapath: accumulators updated.
- `mac_o`  in  128  datapath accumulators, lane i = bits [32i+31:32i] (o0..o3).
- `res_valid`  out  1  result available.
- `res_ready`  in  1  consumer accepts result.
- `res_data`  out  128  captured `mac_o`, same packing.

## Operation
- Buffer: DEPTH×64-bit register array, cleared to 0 on reset. A write occurs on an edge where `wr_en`=1 and `busy`=0. Reads are combinational by step index.
- FSM states and transitions:
  - IDLE → CLEAR on `go` with 1≤`len`≤DEPTH. Latch K=`len` and set idx=0.
  - IDLE: on `go` with `len`=0 or `len`>DEPTH, pulse `err` for one cycle and stay in IDLE.
  - CLEAR: `mac_clr`=1 for one cycle → ISSUE.
  - ISSUE: `mac_start`=1 for one cycle → WAIT.
  - WAIT: `mac_a`/`mac_b` hold buffer[idx] stable. On `mac_done`=1:
    - idx==K−1: capture `mac_o` into `res_data` → OUT.
    - otherwise: idx+1 → ISSUE.
  - OUT: `res_valid`=1 with `res_data` stable until `res_ready`=1 is sampled → IDLE.
- `mac_a`/`mac_b` drive buffer[idx] in ISSUE and WAIT, and 0 in all other states.
- `mac_done` is sampled only in WAIT and ignored in every other state. Exactly one `mac_start` is issued per step regardless of datapath latency.
- `go` and `wr_en` are ignored whenever `busy`=1, including in OUT.
- No arithmetic is done in this block. Results are the datapath's 32-bit two's-complement sums, passed through unmodified. Overflow wraps in the datapath.
- idx runs 0..K−1 with no wrap; K=DEPTH uses every entry.

## Timing
- Reset (asynchronous, any state): state=IDLE, idx=0, buffer=0. All outputs are 0: `busy`, `err`, `mac_clr`, `mac_start`, `mac_a`, `mac_b`, `res_valid`, `res_data`. Outputs go to 0 without waiting for a clock edge.
- Reset mid-run abandons the run. No result is produced; the datapath is cleared by the next run's CLEAR.
- Outputs are registered Moore decodes of state (plus `res_data`/`err` registers). No combinational input→output paths.
- `go` sampled at edge E0: `mac_clr` is high in the cycle after E0, and the first `mac_start` is high in the cycle after that.
- With a 1-cycle datapath (`mac_done` high the cycle after `mac_start`), each step takes 2 cycles. `res_valid` rises after edge E0+1+2K.
- Slower datapath: each step takes 1 + (cycles from ISSUE to `mac_done`).
- OUT with `res_ready` already high: one `res_valid` cycle, then IDLE. The earliest next `go` is accepted on the following edge.

## Test plan
- Load entry0 A=(2,4,−1,8) B=(3,5,7,−2) and entry1 all ones; `len`=2, `go`; 1-cycle MAC model. Required: `res_data` lanes = (7,21,−6,−15), `res_valid` after E0+5, exactly 2 `mac_start` pulses and 1 `mac_clr`.
- Backpressure: hold `res_ready`=0 for 4 cycles. Required: `res_data`/`res_valid` stable, `busy`=1, a `go` and a `wr_en` during OUT have no effect. `res_ready`=1 → IDLE next cycle.
- `go` with `len`=0, then with `len`=DEPTH+1. Required: one `err` pulse each, no `mac_clr`/`mac_start`, `busy` stays 0.
- `len`=DEPTH with a MAC model whose `mac_done` arrives 3 cycles after start. Required: 16 starts, `mac_a`/`mac_b` stable through each WAIT, correct sum of all entries, a spurious `mac_done` in IDLE ignored.
- Assert `rst_n`=0 during WAIT of step 3. Required: all outputs 0 immediately, no `res_valid`. A subsequent run returns a result without any contribution from the aborted run.
- Two back-to-back runs with different buffer contents. Required: the second result excludes the first run's sums, proving `mac_clr` precedes the first `mac_start`.
